btn_event_ctrl: RTL and testbench

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_event_ctrl.sv | 71 +++++++
 tb/tb_btn_event_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl.sv
// Per-channel button event controller: edge detect, saturating hold counter for long presses,
// and a mode-selected interrupt flag (toggle, pulse, level, long-press toggle) with global clear.
module btn_event_ctrl #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned LONG_CYCLES = 50_000_000
) (
    input  logic              clk_out,
    input  logic              rst,
    input  logic [N_CH-1:0]   btn_debounce,
    input  logic [2*N_CH-1:0] mode,
    input  logic              clr,
    output logic [N_CH-1:0]   interrupt_flag,
    output logic [N_CH-1:0]   long_press,
    output logic              any_flag
);

    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LongPre = CNT_W'(LONG_CYCLES - 1);

    logic [N_CH-1:0]            btn_shift_q;
    logic [N_CH-1:0]            rise;
    logic [N_CH-1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_CH-1:0]            flag_q, flag_d;
    logic [N_CH-1:0]            long_press_q, long_press_d;

    always_comb begin
        rise         = btn_debounce & ~btn_shift_q;
        hold_cnt_d   = hold_cnt_q;
        long_press_d = '0;
        flag_d       = flag_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            // Counter saturates at LONG_CYCLES so a single hold yields one pulse only.
            if (!btn_debounce[i]) begin
                hold_cnt_d[i] = '0;
            end else if (hold_cnt_q[i] < LongMax) begin
                hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
            end
            long_press_d[i] = btn_debounce[i] && (hold_cnt_q[i] == LongPre);

            unique case (mode[2*i +: 2])
                2'b00:   flag_d[i] = flag_q[i] ^ rise[i];
                2'b01:   flag_d[i] = rise[i];
                2'b10:   flag_d[i] = btn_debounce[i];
                default: flag_d[i] = flag_q[i] ^ long_press_d[i];
            endcase
        end
        if (clr) begin
            flag_d = '0;
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            btn_shift_q  <= '0;
            hold_cnt_q   <= '0;
            flag_q       <= '0;
            long_press_q <= '0;
        end else begin
            btn_shift_q  <= btn_debounce;
            hold_cnt_q   <= hold_cnt_d;
            flag_q       <= flag_d;
            long_press_q <= long_press_d;
        end
    end

    assign interrupt_flag = flag_q;
    assign long_press     = long_press_q;
    assign any_flag       = |flag_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios then random stimulus, checked against a
// behavioural model that tracks run lengths of high samples per channel.
module tb_btn_event_ctrl;

    localparam int N = 4;
    localparam int L = 8;

    logic           clk_out = 1'b0;
    logic           rst;
    logic           clr;
    logic [N-1:0]   btn;
    logic [2*N-1:0] mode;
    logic [N-1:0]   iflag;
    logic [N-1:0]   lp;
    logic           anyf;

    int checks   = 0;
    int failures = 0;

    int run   [N];
    bit prev  [N];
    bit mflag [N];
    bit mlp   [N];

    btn_event_ctrl #(
        .N_CH        (N),
        .LONG_CYCLES (L)
    ) dut (
        .clk_out        (clk_out),
        .rst            (rst),
        .btn_debounce   (btn),
        .mode           (mode),
        .clr            (clr),
        .interrupt_flag (iflag),
        .long_press     (lp),
        .any_flag       (anyf)
    );

    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            run[i] = 0; prev[i] = 0; mflag[i] = 0; mlp[i] = 0;
        end
    endtask

    // Long press = the L-th consecutive high sample; run is capped above L so it never repeats.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit b, r;
            int m;
            b = btn[i];
            r = b && !prev[i];
            run[i] = b ? run[i] + 1 : 0;
            mlp[i] = (run[i] == L);
            if (run[i] > L) run[i] = L + 1;
            m = int'(mode[2*i +: 2]);
            if (clr) mflag[i] = 0;
            else if (m == 0) mflag[i] = mflag[i] ^ r;
            else if (m == 1) mflag[i] = r;
            else if (m == 2) mflag[i] = b;
            else mflag[i] = mflag[i] ^ mlp[i];
            prev[i] = b;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] ef, el;
        for (int i = 0; i < N; i++) begin
            ef[i] = mflag[i];
            el[i] = mlp[i];
        end
        check({tag, ".flag"}, 32'(iflag), 32'(ef));
        check({tag, ".long"}, 32'(lp), 32'(el));
        check({tag, ".any"}, 32'(anyf), 32'(|ef));
    endtask

    task automatic step(input string tag);
        @(posedge clk_out);
        if (rst) model_reset();
        else model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("reset.flag", 32'(iflag), 32'd0);
        check("reset.long", 32'(lp), 32'd0);
        check("reset.any", 32'(anyf), 32'd0);
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        step("clear");
        clr = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        clr  = 1'b0;
        btn  = '0;
        mode = '0;
        #2;
        do_reset();
        step("in_reset");
        step("in_reset");
        rst = 1'b0;
        step("idle");

        // Toggle mode: three 3-cycle presses on ch0.
        mode = '0;
        for (int p = 0; p < 3; p++) begin
            btn = 4'b0001;
            step("toggle");
            check("toggle.edge", 32'(iflag[0]), (p % 2 == 0) ? 32'd1 : 32'd0);
            step("toggle");
            step("toggle");
            btn = 4'b0000;
            step("toggle");
            step("toggle");
        end
        check("toggle.final", 32'(iflag), 32'h1);

        // Long-press toggle on ch2, held 20 cycles.
        clear_flags();
        mode = 8'b0011_0000;
        btn  = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            step("long");
            check("long.lp2", 32'(lp[2]), (k == L) ? 32'd1 : 32'd0);
        end
        check("long.flag2", 32'(iflag[2]), 32'd1);
        btn = '0;
        step("long");

        // Pulse on ch1, level on ch3.
        clear_flags();
        mode = 8'b1000_0100;
        btn  = 4'b1010;
        for (int k = 1; k <= 4; k++) begin
            step("pl");
            check("pl.pulse1", 32'(iflag[1]), (k == 1) ? 32'd1 : 32'd0);
            check("pl.level3", 32'(iflag[3]), 32'd1);
        end
        btn = '0;
        step("pl");
        check("pl.level3_off", 32'(iflag[3]), 32'd0);
        step("pl");

        // Clear beats a simultaneous rise.
        mode = '0;
        btn  = 4'b0001;
        step("clr");
        btn = '0;
        step("clr");
        check("clr.pre", 32'(iflag[0]), 32'd1);
        btn = 4'b0001;
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
        check("clr.flag0", 32'(iflag[0]), 32'd0);
        check("clr.any", 32'(anyf), 32'd0);
        btn = '0;
        step("clr");

        // Reset mid-hold on ch0 with long-press mode.
        mode = 8'b0000_0011;
        btn  = 4'b0001;
        for (int k = 0; k < 5; k++) step("rsthold");
        do_reset();
        step("rsthold");
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step("rsthold");
            check("rsthold.lp0", 32'(lp[0]), (k == L) ? 32'd1 : 32'd0);
        end
        btn = '0;
        step("rsthold");

        // Short release inside a hold restarts counting.
        btn = 4'b0001;
        for (int k = 0; k < 5; k++) step("gap");
        btn = '0;
        step("gap");
        btn = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step("gap");
            check("gap.lp0", 32'(lp[0]), (k == L) ? 32'd1 : 32'd0);
        end
        btn = '0;
        step("gap");

        // Random traffic: buttons held in bursts, occasional mode change, clear and reset.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) btn = N'($urandom);
            if ($urandom_range(0, 19) == 0) mode = (2*N)'($urandom);
            clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                step("rand_rst");
                rst = 1'b0;
            end
            step("rand");
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
